// File: rtl/chime_sequencer_pkg.sv
// Shared types and default constants for the doorbell chime sequencer.
// The optional debounce filter is enabled by defining CHIME_DEBOUNCE_EN.
package chime_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DING = 2'd1,
        GAP  = 2'd2,
        DONG = 2'd3
    } state_t;

    localparam int DEF_TONE_A_HALF  = 2;
    localparam int DEF_TONE_B_HALF  = 3;
    localparam int DEF_DING_LEN     = 16;
    localparam int DEF_GAP_LEN      = 4;
    localparam int DEF_DONG_LEN     = 24;
    localparam int DEF_DEBOUNCE_LEN = 8;

    // Largest of three lengths; sizes the shared note-duration counter.
    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/chime_sequencer_if.sv
// Button input and multiplexer-facing outputs of the chime sequencer.
// master drives the button and observes the chime; slave is the sequencer.
interface chime_sequencer_if;

    logic button;
    logic a;
    logic b;
    logic sel;
    logic busy;

    modport master (output button, input a, b, sel, busy);
    modport slave  (input button, output a, b, sel, busy);

endinterface

// File: rtl/chime_sequencer_tone_gen.sv
// Square-wave tone generator: starts high when en rises, toggles every
// HALF cycles while en is high, and is held low while en is low.
module tone_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone
);

    localparam int HW = $clog2(HALF + 1);

    logic [HW-1:0] cnt_q;
    logic          en_q;
    logic          tone_q;

    // Phase counter and tone level; a rising en restarts the waveform high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            tone_q <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                tone_q <= 1'b0;
                cnt_q  <= '0;
            end else if (!en_q) begin
                tone_q <= 1'b1;
                cnt_q  <= '0;
            end else if (cnt_q == HW'(HALF - 1)) begin
                tone_q <= ~tone_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/chime_sequencer.sv
// Doorbell "ding-dong" sequencer: synchronised button press -> tone A,
// silence, tone B. Define CHIME_DEBOUNCE_EN to insert a debounce filter
// between the synchroniser and the press edge detector.
module chime_sequencer
    import chime_pkg::*;
#(
    parameter int TONE_A_HALF  = DEF_TONE_A_HALF,
    parameter int TONE_B_HALF  = DEF_TONE_B_HALF,
    parameter int DING_LEN     = DEF_DING_LEN,
    parameter int GAP_LEN      = DEF_GAP_LEN,
    parameter int DONG_LEN     = DEF_DONG_LEN,
    parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    chime_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(max3(DING_LEN, GAP_LEN, DONG_LEN)) + 1;

    if (TONE_A_HALF < 1 || TONE_B_HALF < 1 || DING_LEN < 1 || GAP_LEN < 1 ||
        DONG_LEN < 1 || DEBOUNCE_LEN < 1) begin : g_param_check
        $error("chime_sequencer: every length parameter must be at least 1");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_q;
    logic press;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
        end
    end

`ifdef CHIME_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_LEN) + 1;

    logic [DB_W-1:0] db_cnt_q;
    logic            filt_q;

    // Filtered level follows the synchronised level only after it has
    // disagreed for DEBOUNCE_LEN consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            filt_q   <= 1'b0;
        end else if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_LEN - 1)) begin
                filt_q   <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             sel_q;

    // Next state and shared note-duration counter (cleared on every entry).
    // NOTE: defaults assigned first so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (press)                             state_d = DING;
            DING: if (cnt_q == CNT_W'(DING_LEN - 1))     state_d = GAP;
            GAP:  if (cnt_q == CNT_W'(GAP_LEN - 1))      state_d = DONG;
            DONG: if (cnt_q == CNT_W'(DONG_LEN - 1))     state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end

    // State, counter and registered select/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            sel_q   <= (state_d == DONG);
        end
    end

    logic tone_a;
    logic tone_b;

    // Enables look at the next state so each tone starts on its entry edge.
    tone_gen #(.HALF(TONE_A_HALF)) u_tone_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_d == DING),
        .tone  (tone_a)
    );

    tone_gen #(.HALF(TONE_B_HALF)) u_tone_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_d == DONG),
        .tone  (tone_b)
    );

    assign bus.a    = tone_a;
    assign bus.b    = tone_b;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Directed bench for chime_sequencer with a scoreboard of expected
// {a,b,sel,busy} vectors. Honors CHIME_DEBOUNCE_EN when defined.
module tb_chime_sequencer;

    localparam int DING  = 16;
    localparam int GAP   = 4;
    localparam int DONG  = 24;
    localparam int CHIME = DING + GAP + DONG;
    localparam int DEB   = 8;
`ifdef CHIME_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    chime_sequencer_if bus_if ();

    chime_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [3:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    int   pos;
    logic last_busy;
    logic prev_lvl;
    logic filt;
    int   streak;

    // Expected {a,b,sel,busy} at position p of a chime.
    function automatic logic [3:0] chime_entry(input int p);
        int j;
        if (p < DING) begin
            return (((p / 2) % 2) == 0) ? 4'b1001 : 4'b0001;
        end else if (p < DING + GAP) begin
            return 4'b0001;
        end
        j = p - DING - GAP;
        return (((j / 3) % 2) == 0) ? 4'b0111 : 4'b0011;
    endfunction

    function automatic logic [3:0] outs();
        return {bus_if.a, bus_if.b, bus_if.sel, bus_if.busy};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b (a,b,sel,busy)", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        pos       = CHIME;
        last_busy = 1'b0;
        prev_lvl  = 1'b0;
        filt      = 1'b0;
        streak    = 0;
        repeat (LAT) exp_q.push_back(4'b0000);
    endtask

    // One cycle: compare against the scoreboard, drive the button, and
    // push the vector this button value implies LAT cycles later.
    task automatic step(input logic btn);
        logic [3:0] nxt;
        logic       rise;
        @(negedge clk);
        total++;
        assert (exp_q.size() != 0)
        else begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%0d expected=nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) check("chime_out", outs(), exp_q.pop_front());
        bus_if.button = btn;
`ifdef CHIME_DEBOUNCE_EN
        if (btn != filt) begin
            streak++;
            if (streak == DEB) begin
                filt   = btn;
                streak = 0;
            end
        end else begin
            streak = 0;
        end
        rise     = filt && !prev_lvl;
        prev_lvl = filt;
`else
        rise     = btn && !prev_lvl;
        prev_lvl = btn;
`endif
        if (pos < CHIME) begin
            nxt = chime_entry(pos);
            pos++;
        end else if (rise && !last_busy) begin
            nxt = chime_entry(0);
            pos = 1;
        end else begin
            nxt = 4'b0000;
        end
        last_busy = nxt[0];
        exp_q.push_back(nxt);
    endtask

    task automatic steps(input logic btn, input int n);
        for (int i = 0; i < n; i++) step(btn);
    endtask

    initial begin
        bus_if.button = 1'b0;

        // Reset held while the button toggles: outputs stay quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_if.button = ~bus_if.button;
            check("reset_hold", outs(), 4'b0000);
        end
        bus_if.button = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Single press.
        steps(1'b0, 4);
        steps(1'b1, 5);
        steps(1'b0, 50);

        // Second press during DONG is ignored.
        steps(1'b1, 3);
        steps(1'b0, 28);
        steps(1'b1, 2);
        steps(1'b0, 20);

        // Held across the end: no retrigger; short release then new press.
        steps(1'b1, 60);
        steps(1'b0, 3);
        steps(1'b1, 5);
        steps(1'b0, 50);

        // Short glitch, then a long press.
        steps(1'b1, 3);
        steps(1'b0, 50);
        steps(1'b1, 12);
        steps(1'b0, 60);

        // Reset during cycle 8 of DING.
        steps(1'b1, 2);
        steps(1'b0, LAT + 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", outs(), 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_mid", outs(), 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        steps(1'b0, 60);
        steps(1'b1, 5);
        steps(1'b0, 55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
